alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered ID→EX issue stage that sits directly upstream of the 32-bit ALU. Accepts one decoded-but-unexpanded RV32I instruction per cycle with its register-file read data. Resolves operand forwarding, selects ALU operands A/B, and produces the 4-bit ALU control code. Presents the result in a valid/ready pipeline register that drives the ALU inputs.

## Interface
- FWD_EN, 1, 1 = EX/MEM and MEM/WB forwarding enabled; 0 = register-file data used unmodified.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- flush  in  1  kill the held entry and any entry offered this cycle.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  32  instruction PC.
- in_rs1_data, in_rs2_data  in  32 each  register-file read data.
- exm_wr, exm_rd, exm_data  in  1/5/32  EX/MEM writeback candidate.
- wb_wr, wb_rd, wb_data  in  1/5/32  MEM/WB writeback candidate.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream (EX/MEM) consumes this cycle.
- alu_a, alu_b  out  32 each  ALU operands.
- alu_control  out  4  ALU op code.
- out_rd  out  5  destination register.
- out_reg_write  out  1  result is to be written back.
- out_illegal  out  1  opcode or funct combination not supported.

## Operation
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLTU 1000, SLT 1001.
- OP (0110011):
  - funct3 000: funct7 0x00 → ADD, 0x20 → SUB.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; these require funct7 0x00.
  - 101: funct7 0x00 → SRL, 0x20 → SRA.
  - A = rs1, B = rs2.
- OP-IMM (0010011):
  - Same funct3 map without SUB; ADDI/SLTI/SLTIU/XORI/ORI/ANDI ignore funct7.
  - SLLI requires imm[11:5] = 0x00; SRLI/SRAI require 0x00/0x20.
  - A = rs1, B = sign-extended I-immediate.
- LUI (0110111): A = 0, B = {instr[31:12], 12'b0}, ADD.
- AUIPC (0010111): A = in_pc, B = U-immediate, ADD.
- Any other opcode or disallowed funct7 → out_illegal = 1, out_reg_write = 0, alu_control = ADD, A = B = 0.
- out_reg_write = 1 for legal instructions with rd ≠ 0; out_rd = instr[11:7].
- Operand resolution per source rs ∈ {rs1, rs2}:
  - rs = 0 → 0.
  - else if FWD_EN & exm_wr & exm_rd == rs → exm_data.
  - else if FWD_EN & wb_wr & wb_rd == rs → wb_data.
  - else register-file data.
  - EX/MEM has priority over MEM/WB.
- Forwarding is sampled only in the accept cycle; held entries are not re-resolved.

## Timing
- One output register; latency 1 cycle from accept to out_valid.
- in_ready = !out_valid | out_ready (combinational; full throughput with back-to-back transfers).
- Accept occurs when in_valid & in_ready & !flush.
- Output register update priority:
  - rst: out_valid = 0, alu_a = alu_b = 0, alu_control = 0000, out_rd = 0, out_reg_write = 0, out_illegal = 0.
  - flush: out_valid = 0, other outputs don't-care, the offered instruction is dropped. flush wins over a simultaneous accept and over a stall.
  - accept: load new entry, out_valid = 1.
  - out_ready & out_valid without accept: out_valid = 0.
  - otherwise hold.
- Stall (out_valid & !out_ready): all outputs held bit-stable; in_ready = 0.
- Reset mid-stall discards the held entry; in_ready = 1 in the first cycle after reset deasserts.

## Structure
- Shared package rv_alu_pkg: ALU control localparams (the 10 codes above), opcode constants (OP, OP_IMM, LUI, AUIPC), funct7 constants 0x00/0x20. The ALU consumes the same package.
- Sub-module alu_ctrl_decode: purely combinational; maps instr → alu_control, operand-select, immediate, illegal, reg_write.
- The top level holds forwarding muxes and the valid/ready register.

## Test plan
- Back-to-back transfers with out_ready = 1: ADD x3,x1,x2 (rs1 = 5, rs2 = 7), then SUB, then SRAI x4,x1,3 → alu_control 0000, 0001, 0111 on consecutive cycles; alu_b = 3 for SRAI; in_ready never drops.
- Forward priority: rs1 = x5, exm (wr,5,0xAAAA) and wb (wr,5,0xBBBB) → alu_a = 0xAAAA. With exm_wr = 0 → 0xBBBB. With rs1 = x0 and exm_rd = 0 → alu_a = 0.
- Immediates:
  - LUI x1,0xFFFFF → A = 0, B = 0xFFFFF000.
  - AUIPC at pc 0x100 → A = 0x100.
  - ADDI imm −1 → B = 0xFFFFFFFF.
- Stall: out_ready = 0 for 3 cycles → in_ready = 0 and outputs bit-stable. Release → next instruction loads on the following cycle.
- Flush: flush coincides with accept while holding a stalled entry → out_valid = 0 next cycle and neither instruction reaches the output. rst during a stall → all outputs zero.
- Illegal inputs: opcode 0000011, and SLLI with imm[11:5] = 0x20 → out_illegal = 1, out_reg_write = 0, alu_control = 0000.

Source files
------------

// File: rtl/rv_alu_pkg.sv
// Shared RV32I ALU definitions: control codes, opcodes, funct7 values and operand-select types.
// Both the issue stage and the ALU import this package.
package rv_alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {A_RS1, A_ZERO, A_PC} a_sel_e;
  typedef enum logic {B_RS2, B_IMM} b_sel_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode for the ALU: control code, operand selects, immediate,
// illegal flag and write-back enable.
module alu_ctrl_decode
  import rv_alu_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [3:0]      alu_control,
  output a_sel_e          a_sel,
  output b_sel_e          b_sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic            reg_write
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic signed [31:0] imm_i;
  logic [31:0]       shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign shamt  = {27'd0, instr[24:20]};

  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    alu_control = ALU_ADD;
    a_sel       = A_ZERO;
    b_sel       = B_IMM;
    imm         = '0;
    illegal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_sel       = A_RS1;
        b_sel       = B_RS2;
        alu_control = f3_to_alu(funct3);
        if (funct7 == F7_ALT && funct3 == 3'b000)      alu_control = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) alu_control = ALU_SRA;
        else if (funct7 != F7_BASE)                    illegal     = 1'b1;
      end
      OPC_OP_IMM: begin
        a_sel       = A_RS1;
        alu_control = f3_to_alu(funct3);
        imm         = imm_i;
        // Shift immediates carry only the shift amount; imm[11:5] selects the variant.
        if (funct3 == 3'b001) begin
          imm     = shamt;
          illegal = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          imm = shamt;
          if (funct7 == F7_ALT)       alu_control = ALU_SRA;
          else if (funct7 != F7_BASE) illegal     = 1'b1;
        end
      end
      OPC_LUI: begin
        imm = {instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        a_sel = A_PC;
        imm   = {instr[31:12], 12'd0};
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_control = ALU_ADD;
      a_sel       = A_ZERO;
      b_sel       = B_IMM;
      imm         = '0;
    end
  end

  assign reg_write = !illegal && (instr[11:7] != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: operand forwarding, ALU operand/control selection and a
// single valid/ready output register feeding the ALU.
module alu_issue_stage
  import rv_alu_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            exm_wr,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            wb_wr,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_illegal
);

  logic [3:0]      ctl_p0;
  a_sel_e          a_sel_p0;
  b_sel_e          b_sel_p0;
  logic [XLEN-1:0] imm_p0;
  logic            ill_p0;
  logic            rw_p0;
  logic [XLEN-1:0] rs1_val_p0;
  logic [XLEN-1:0] rs2_val_p0;
  logic [XLEN-1:0] a_p0;
  logic [XLEN-1:0] b_p0;
  logic            accept;

  logic            vld_p1;
  logic [XLEN-1:0] a_p1;
  logic [XLEN-1:0] b_p1;
  logic [3:0]      ctl_p1;
  logic [4:0]      rd_p1;
  logic            rw_p1;
  logic            ill_p1;

  // EX/MEM is the younger result, so it wins over MEM/WB.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            e_wr,
    input logic [4:0]      e_rd,
    input logic [XLEN-1:0] e_data,
    input logic            w_wr,
    input logic [4:0]      w_rd,
    input logic [XLEN-1:0] w_data
  );
    if (rs == 5'd0)                        return '0;
    else if (FWD_EN && e_wr && e_rd == rs) return e_data;
    else if (FWD_EN && w_wr && w_rd == rs) return w_data;
    else                                   return rf_data;
  endfunction

  alu_ctrl_decode u_decode (
    .instr       (in_instr),
    .alu_control (ctl_p0),
    .a_sel       (a_sel_p0),
    .b_sel       (b_sel_p0),
    .imm         (imm_p0),
    .illegal     (ill_p0),
    .reg_write   (rw_p0)
  );

  // Stage p0: operand resolution in the accept cycle
  assign rs1_val_p0 = resolve(in_instr[19:15], in_rs1_data, exm_wr, exm_rd, exm_data,
                              wb_wr, wb_rd, wb_data);
  assign rs2_val_p0 = resolve(in_instr[24:20], in_rs2_data, exm_wr, exm_rd, exm_data,
                              wb_wr, wb_rd, wb_data);

  always_comb begin
    a_p0 = '0;
    case (a_sel_p0)
      A_RS1:   a_p0 = rs1_val_p0;
      A_PC:    a_p0 = in_pc;
      default: a_p0 = '0;
    endcase
    b_p0 = (b_sel_p0 == B_RS2) ? rs2_val_p0 : imm_p0;
  end

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Stage p1: output register driving the ALU
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      ctl_p1 <= ALU_ADD;
      rd_p1  <= '0;
      rw_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      a_p1   <= a_p0;
      b_p1   <= b_p0;
      ctl_p1 <= ctl_p0;
      rd_p1  <= in_instr[11:7];
      rw_p1  <= rw_p0;
      ill_p1 <= ill_p0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid     = vld_p1;
  assign alu_a         = a_p1;
  assign alu_b         = b_p1;
  assign alu_control   = ctl_p1;
  assign out_rd        = rd_p1;
  assign out_reg_write = rw_p1;
  assign out_illegal   = ill_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic        exm_wr, wb_wr;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_data, wb_data;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_illegal;

  always #5 clk = ~clk;

  alu_issue_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_illegal(out_illegal)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  typedef struct packed {
    logic        ill;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        rw;
    logic [4:0]  rd;
  } exp_t;

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 0;
    if (exm_wr && exm_rd == rs) return exm_data;
    if (wb_wr && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  // Reference: what the ALU must see for the instruction currently offered.
  function automatic exp_t model_now();
    exp_t        e;
    logic [3:0]  by_f3 [8];
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic        legal, shift;
    by_f3 = '{4'b0000, 4'b0101, 4'b1001, 4'b1000, 4'b0100, 4'b0110, 4'b0011, 4'b0010};
    op = in_instr[6:0];
    f3 = in_instr[14:12];
    f7 = in_instr[31:25];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    e = '0;
    legal = 1'b1;
    e.ctl = by_f3[f3];
    if (op == 7'h33) begin
      legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      if (f7 == 7'h20) e.ctl = (f3 == 0) ? 4'b0001 : 4'b0111;
      e.a = fwd(in_instr[19:15], in_rs1_data);
      e.b = fwd(in_instr[24:20], in_rs2_data);
    end else if (op == 7'h13) begin
      legal = !shift || f7 == 0 || (f3 == 5 && f7 == 7'h20);
      if (f3 == 5 && f7 == 7'h20) e.ctl = 4'b0111;
      e.a = fwd(in_instr[19:15], in_rs1_data);
      e.b = shift ? 32'(in_instr[24:20]) : 32'($signed(in_instr[31:20]));
    end else if (op == 7'h37) begin
      e.ctl = 0; e.a = 0; e.b = in_instr[31:12] << 12;
    end else if (op == 7'h17) begin
      e.ctl = 0; e.a = in_pc; e.b = in_instr[31:12] << 12;
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin e.ctl = 0; e.a = 0; e.b = 0; end
    e.ill = !legal;
    e.rd  = in_instr[11:7];
    e.rw  = legal && e.rd != 0;
    return e;
  endfunction

  logic m_vld;
  exp_t m_e;
  bit   chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_vld <= 1'b0;
      m_e   <= '0;
    end else if (flush) begin
      m_vld <= 1'b0;
    end else if (in_valid && (!m_vld || out_ready)) begin
      m_vld <= 1'b1;
      m_e   <= model_now();
    end else if (out_ready) begin
      m_vld <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", in_ready, !m_vld || out_ready);
      chk("out_valid", out_valid, m_vld);
      if (m_vld) begin
        chk("alu_a", alu_a, m_e.a);
        chk("alu_b", alu_b, m_e.b);
        chk("alu_control", alu_control, m_e.ctl);
        chk("out_rd", out_rd, m_e.rd);
        chk("out_reg_write", out_reg_write, m_e.rw);
        chk("out_illegal", out_illegal, m_e.ill);
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc, r1, r2);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                         input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    exm_wr = ew; exm_rd = er; exm_data = ed; wb_wr = ww; wb_rd = wr; wb_data = wd;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_a"}, alu_a, 0);
    chk({tag, "_b"}, alu_b, 0);
    chk({tag, "_ctl"}, alu_control, 0);
    chk({tag, "_rd"}, out_rd, 0);
    chk({tag, "_rw"}, out_reg_write, 0);
    chk({tag, "_ill"}, out_illegal, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    int         k;
    k   = int'($urandom_range(0, 9));
    f3  = 3'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if (k <= 3) return enc_r(f7, rs2, rs1, f3, rd, 7'h33);
    if (k <= 6) begin
      if (f3 == 1 || f3 == 5) return enc_r(f7, rs2, rs1, f3, rd, 7'h13);
      return {12'($urandom), rs1, f3, rd, 7'h13};
    end
    if (k == 7) return {20'($urandom), rd, 7'h37};
    if (k == 8) return {20'($urandom), rd, 7'h17};
    return $urandom;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0;
    set_fwd(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk_zero_outputs("reset");
    rst = 1'b0;
    chk_on = 1'b1;

    // Back-to-back ADD, SUB, SRAI
    offer(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 0, 5, 7);
    #1 chk("b2b_ready0", in_ready, 1);
    tick();
    chk("add_ctl", alu_control, 4'b0000);
    chk("add_a", alu_a, 5);
    chk("add_b", alu_b, 7);
    offer(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 0, 5, 7);
    #1 chk("b2b_ready1", in_ready, 1);
    tick();
    chk("sub_ctl", alu_control, 4'b0001);
    offer(enc_r(7'h20, 5'd3, 5'd1, 3'd5, 5'd4, 7'h13), 0, 5, 7);
    #1 chk("b2b_ready2", in_ready, 1);
    tick();
    chk("srai_ctl", alu_control, 4'b0111);
    chk("srai_b", alu_b, 3);
    chk("srai_valid", out_valid, 1);

    // Forwarding priority
    offer(enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd6, 7'h33), 0, 32'h1111, 32'h2222);
    set_fwd(1, 5, 32'hAAAA, 1, 5, 32'hBBBB);
    tick();
    chk("fwd_exm", alu_a, 32'hAAAA);
    chk("fwd_rs2_x0", alu_b, 0);
    set_fwd(0, 5, 32'hAAAA, 1, 5, 32'hBBBB);
    tick();
    chk("fwd_wb", alu_a, 32'hBBBB);
    offer(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd6, 7'h33), 0, 32'h1111, 32'h2222);
    set_fwd(1, 0, 32'hCCCC, 1, 0, 32'hDDDD);
    tick();
    chk("fwd_x0", alu_a, 0);
    set_fwd(0, 0, 0, 0, 0, 0);

    // Immediates
    offer({20'hFFFFF, 5'd1, 7'h37}, 0, 9, 9);
    tick();
    chk("lui_a", alu_a, 0);
    chk("lui_b", alu_b, 32'hFFFFF000);
    offer({20'h00001, 5'd2, 7'h17}, 32'h100, 9, 9);
    tick();
    chk("auipc_a", alu_a, 32'h100);
    chk("auipc_b", alu_b, 32'h1000);
    offer({12'hFFF, 5'd2, 3'd0, 5'd1, 7'h13}, 0, 9, 9);
    tick();
    chk("addi_b", alu_b, 32'hFFFFFFFF);

    // Illegal encodings
    offer({12'h004, 5'd2, 3'd2, 5'd1, 7'h03}, 0, 9, 9);
    tick();
    chk("load_ill", out_illegal, 1);
    chk("load_rw", out_reg_write, 0);
    chk("load_ctl", alu_control, 0);
    offer(enc_r(7'h20, 5'd3, 5'd1, 3'd1, 5'd4, 7'h13), 0, 9, 9);
    tick();
    chk("slli_ill", out_illegal, 1);
    chk("slli_rw", out_reg_write, 0);
    chk("slli_a", alu_a, 0);

    // Stall for three cycles, then release
    offer(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 0, 10, 20);
    tick();
    out_ready = 1'b0;
    offer(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 0, 1, 2);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", in_ready, 0);
      tick();
      chk("stall_a", alu_a, 10);
      chk("stall_ctl", alu_control, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("release_ctl", alu_control, 4'b0001);
    chk("release_a", alu_a, 1);

    // Flush while holding a stalled entry, with a new offer
    offer(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd3, 7'h33), 0, 3, 4);
    tick();
    out_ready = 1'b0;
    tick();
    flush = 1'b1;
    offer(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd3, 7'h33), 0, 3, 4);
    tick();
    chk("flush_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_valid2", out_valid, 0);

    // Reset during a stall
    out_ready = 1'b1;
    offer(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33), 32'h40, 33, 44);
    tick();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk_zero_outputs("rst_stall");
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("post_rst_ready", in_ready, 1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_instr    = rand_instr();
      in_pc       = $urandom & 32'hFFFF_FFFC;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      tick();
    end

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
